// File: rtl/bf_sched_pkg.sv
// bf_sched_pkg: shared constants and FSM encoding for the FFT butterfly sequencer
package bf_sched_pkg;
    localparam int CPLX_WIDTH   = 32;
    localparam int REAL_MSB     = 31;
    localparam int REAL_LSB     = 16;
    localparam int IMGN_MSB     = 15;
    localparam int IMGN_LSB     = 0;
    localparam int DEF_LOG2N    = 6;
    localparam int DEF_PIPE_LAT = 3;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/bf_dly.sv
// bf_dly: valid+data shift register with synchronous clear
module bf_dly
    import bf_sched_pkg::*;
#(
    parameter int DEPTH = DEF_PIPE_LAT,
    parameter int W     = 2 * DEF_LOG2N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         d_vld,
    input  logic [W-1:0] d_data,
    output logic         q_vld,
    output logic [W-1:0] q_data
);
    logic [W:0] sr [DEPTH];
    // shift {valid, data} one slot per cycle; reset drops every pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= {d_vld, d_data};
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end
    assign {q_vld, q_data} = sr[DEPTH-1];
endmodule

// File: rtl/bf_sched.sv
// bf_sched: read/twiddle/write-back sequencer for an in-place radix-2 DIF FFT
module bf_sched
    import bf_sched_pkg::*;
#(
    parameter int LOG2N    = DEF_LOG2N,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    localparam int SW      = $clog2(LOG2N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inverse,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic             tw_conj,
    output logic [SW-1:0]    stage,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b
);
    localparam int N  = 1 << LOG2N;
    localparam int DW = $clog2(PIPE_LAT + 1);
    state_t             state;
    logic [LOG2N-2:0]   j, j_n;
    logic [DW-1:0]      dc;
    logic [SW-1:0]      s_n;
    logic [LOG2N-1:0]   span_n, k_n, g_n, a_n;
    logic               more, dc_last, issue;
    logic [2*LOG2N-1:0] wr_data;
    // next butterfly to issue and its operand/twiddle addresses
    always_comb begin
        more    = stage < SW'(LOG2N - 1);
        dc_last = dc == DW'(PIPE_LAT - 1);
        issue   = (state == IDLE && start) || (state == RUN && !(&j)) || (state == DRAIN && dc_last && more);
        s_n     = state == DRAIN ? stage + SW'(1) : state == RUN ? stage : '0;
        j_n     = state == RUN ? j + (LOG2N-1)'(1) : '0;
        span_n  = LOG2N'(N >> (int'(s_n) + 1));
        k_n     = {1'b0, j_n} & (span_n - LOG2N'(1));
        g_n     = {1'b0, j_n} >> (LOG2N - 1 - int'(s_n));
        a_n     = (g_n << (LOG2N - int'(s_n))) | k_n;
    end
    // control FSM with registered read-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            j         <= '0;
            dc        <= '0;
            stage     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tw_conj   <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    busy    <= 1'b1;
                    tw_conj <= inverse;
                end
                RUN: if (&j) begin
                    state <= DRAIN;
                    dc    <= '0;
                end
                DRAIN: begin
                    dc <= dc + DW'(1);
                    if (dc_last) begin
                        state <= more ? RUN : DONE;
                        done  <= !more;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    stage <= '0;
                end
            endcase
            rd_en <= issue;
            if (issue) begin
                j         <= j_n;
                stage     <= s_n;
                rd_addr_a <= a_n;
                rd_addr_b <= a_n | span_n;
                tw_idx    <= (LOG2N-1)'(k_n << s_n);
            end
        end
    end
    bf_dly #(.DEPTH(PIPE_LAT), .W(2 * LOG2N)) u_dly (
        .clk    (clk),
        .rst    (rst),
        .d_vld  (rd_en),
        .d_data ({rd_addr_a, rd_addr_b}),
        .q_vld  (wr_en),
        .q_data (wr_data)
    );
    assign {wr_addr_a, wr_addr_b} = wr_data;
endmodule

// File: tb/tb_bf_sched.sv
// tb_bf_sched: directed vectors and multi-cycle sequences for bf_sched
module tb_bf_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic start8 = 1'b0, inv8 = 1'b0, start64 = 1'b0, inv64 = 1'b0;
    logic b8, d8, re8, cj8, we8;
    logic [2:0] ra8, rb8, wa8, wb8;
    logic [1:0] tw8, st8;
    logic b64, d64, re64, cj64, we64;
    logic [5:0] ra64, rb64, wa64, wb64;
    logic [4:0] tw64;
    logic [2:0] st64;
    bf_sched #(.LOG2N(3), .PIPE_LAT(1)) u8 (
        .clk(clk), .rst(rst), .start(start8), .inverse(inv8), .busy(b8), .done(d8),
        .rd_en(re8), .rd_addr_a(ra8), .rd_addr_b(rb8), .tw_idx(tw8), .tw_conj(cj8),
        .stage(st8), .wr_en(we8), .wr_addr_a(wa8), .wr_addr_b(wb8)
    );
    bf_sched #(.LOG2N(6), .PIPE_LAT(3)) u64 (
        .clk(clk), .rst(rst), .start(start64), .inverse(inv64), .busy(b64), .done(d64),
        .rd_en(re64), .rd_addr_a(ra64), .rd_addr_b(rb64), .tw_idx(tw64), .tw_conj(cj64),
        .stage(st64), .wr_en(we64), .wr_addr_a(wa64), .wr_addr_b(wb64)
    );
    int nvec = 0, nerr = 0;
    typedef struct {
        logic start, busy, done, rd;
        int   a, b, tw, st;
        logic wr;
        int   wa, wb;
    } vec_t;
    vec_t tbl[18];
    int m_a[192], m_b[192], m_tw[192], m_st[192];
    logic l_rd[1024], l_wr[1024], l_done[1024], l_busy[1024], l_conj[1024];
    logic [5:0] l_ra[1024], l_rb[1024], l_wa[1024], l_wb[1024];
    logic [4:0] l_tw[1024];
    logic [2:0] l_st[1024];
    logic s_start[1024], s_inv[1024], s_rst[1024];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, bsy, dn, rd, input int a, b, tw, st,
                                input logic wr, input int wa, wb);
        vec_t v;
        v.start = s; v.busy = bsy; v.done = dn; v.rd = rd;
        v.a = a; v.b = b; v.tw = tw; v.st = st;
        v.wr = wr; v.wa = wa; v.wb = wb;
        return v;
    endfunction

    task automatic clr_sched();
        for (int i = 0; i < 1024; i++) begin
            s_start[i] = 1'b0; s_inv[i] = 1'b0; s_rst[i] = 1'b0;
        end
    endtask

    // log dut64 outputs of cycle t, then drive the scheduled inputs for cycle t
    task automatic run64(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk); #1;
            l_rd[t] = re64; l_wr[t] = we64; l_done[t] = d64; l_busy[t] = b64; l_conj[t] = cj64;
            l_ra[t] = ra64; l_rb[t] = rb64; l_wa[t] = wa64; l_wb[t] = wb64;
            l_tw[t] = tw64; l_st[t] = st64;
            start64 = s_start[t]; inv64 = s_inv[t]; rst = s_rst[t];
        end
        start64 = 1'b0; rst = 1'b0;
    endtask

    // check one N=64 transform whose start was sampled in cycle b
    task automatic analyze(input int b, input logic cx, input string nm);
        int fin, nr, nw, nd, bad, haz, be, ce, p;
        logic rp;
        fin = b + 211; nr = 0; nw = 0; nd = 0; bad = 0; haz = 0; be = 0; ce = 0;
        for (int c = b + 1; c <= fin; c++) begin
            nd += int'(l_done[c]);
            if (l_busy[c] !== 1'b1) be++;
            if (l_conj[c] !== cx) ce++;
            if (l_wr[c]) nw++;
            p = c - 3;
            rp = p >= 0 ? l_rd[p] : 1'b0;
            if (l_wr[c] !== rp || (l_wr[c] && (l_wa[c] !== l_ra[p] || l_wb[c] !== l_rb[p]))) bad++;
            if (l_rd[c]) begin
                if (nr < 192)
                    chk({nm, "_rd"}, {l_ra[c], l_rb[c], l_tw[c], l_st[c]},
                        {6'(m_a[nr]), 6'(m_b[nr]), 5'(m_tw[nr]), 3'(m_st[nr])});
                nr++;
                for (int d = 1; d <= 3; d++)
                    if (c - d >= 0 && l_rd[c-d] &&
                        (l_ra[c] == l_ra[c-d] || l_ra[c] == l_rb[c-d] ||
                         l_rb[c] == l_ra[c-d] || l_rb[c] == l_rb[c-d])) haz++;
            end
        end
        if (l_busy[fin+1] !== 1'b0) be++;
        chk({nm, "_nrd"}, nr, 192);
        chk({nm, "_nwr"}, nw, 192);
        chk({nm, "_ndone"}, nd, 1);
        chk({nm, "_done_cyc"}, l_done[fin], 1);
        chk({nm, "_done_pulse"}, l_done[fin+1], 0);
        chk({nm, "_busy_errs"}, be, 0);
        chk({nm, "_conj_errs"}, ce, 0);
        chk({nm, "_wr_align_errs"}, bad, 0);
        chk({nm, "_hazards"}, haz, 0);
        chk({nm, "_stage_last"}, l_st[fin], 5);
        chk({nm, "_stage_idle"}, l_st[fin+1], 0);
    endtask

    initial begin
        int mi, ex;
        mi = 0;
        for (int s = 0; s < 6; s++)
            for (int a = 0; a < 64; a++)
                if ((a & (32 >> s)) == 0) begin
                    m_a[mi] = a; m_b[mi] = a | (32 >> s);
                    m_tw[mi] = (a % (32 >> s)) << s; m_st[mi] = s;
                    mi++;
                end
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 1, 0, 4, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 1, 1, 5, 1, 0, 1, 0, 4);
        tbl[3]  = mk(0, 1, 0, 1, 2, 6, 2, 0, 1, 1, 5);
        tbl[4]  = mk(0, 1, 0, 1, 3, 7, 3, 0, 1, 2, 6);
        tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 7);
        tbl[6]  = mk(0, 1, 0, 1, 0, 2, 0, 1, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 1, 1, 3, 2, 1, 1, 0, 2);
        tbl[8]  = mk(0, 1, 0, 1, 4, 6, 0, 1, 1, 1, 3);
        tbl[9]  = mk(0, 1, 0, 1, 5, 7, 2, 1, 1, 4, 6);
        tbl[10] = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 5, 7);
        tbl[11] = mk(0, 1, 0, 1, 0, 1, 0, 2, 0, 0, 0);
        tbl[12] = mk(0, 1, 0, 1, 2, 3, 0, 2, 1, 0, 1);
        tbl[13] = mk(0, 1, 0, 1, 4, 5, 0, 2, 1, 2, 3);
        tbl[14] = mk(0, 1, 0, 1, 6, 7, 0, 2, 1, 4, 5);
        tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 2, 1, 6, 7);
        tbl[16] = mk(0, 1, 1, 0, 0, 0, 0, 2, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset, then idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle64", {b64, d64, re64, ra64, rb64, tw64, cj64, st64, we64, wa64, wb64}, 0);
            chk("idle8", {b8, d8, re8, ra8, rb8, tw8, cj8, st8, we8, wa8, wb8}, 0);
        end
        // N=8, PIPE_LAT=1 cycle table
        for (int c = 0; c < 18; c++) begin
            @(posedge clk); #1;
            chk("n8_ctl", {b8, d8, re8, we8, st8, cj8},
                {tbl[c].busy, tbl[c].done, tbl[c].rd, tbl[c].wr, 2'(tbl[c].st), 1'b0});
            if (tbl[c].rd) chk("n8_rd", {ra8, rb8, tw8}, {3'(tbl[c].a), 3'(tbl[c].b), 2'(tbl[c].tw)});
            if (tbl[c].wr) chk("n8_wr", {wa8, wb8}, {3'(tbl[c].wa), 3'(tbl[c].wb)});
            start8 = tbl[c].start;
        end
        // N=64 plain transform
        clr_sched();
        s_start[0] = 1'b1;
        run64(230);
        analyze(0, 1'b0, "n64");
        // starts while busy and in the DONE cycle are ignored, inverse toggling
        clr_sched();
        s_start[0] = 1'b1;
        for (int t = 1; t < 240; t++) s_inv[t] = 1'((t % 2));
        s_start[5] = 1'b1; s_start[50] = 1'b1; s_start[211] = 1'b1;
        run64(240);
        analyze(0, 1'b0, "busy_start");
        ex = 0;
        for (int t = 212; t < 240; t++) ex += int'(l_rd[t]) + int'(l_busy[t]);
        chk("busy_start_after_done", ex, 0);
        // reset mid-transform, coincident with a start
        clr_sched();
        s_start[0] = 1'b1;
        s_rst[40] = 1'b1; s_start[40] = 1'b1; s_inv[40] = 1'b1;
        run64(60);
        chk("rst_zero", {l_busy[41], l_done[41], l_rd[41], l_ra[41], l_rb[41], l_tw[41], l_conj[41],
                         l_st[41], l_wr[41], l_wa[41], l_wb[41]}, 0);
        ex = 0;
        for (int t = 41; t < 60; t++) ex += int'(l_rd[t]) + int'(l_wr[t]) + int'(l_busy[t]);
        chk("rst_quiet", ex, 0);
        clr_sched();
        s_start[0] = 1'b1; s_inv[0] = 1'b1;
        run64(220);
        analyze(0, 1'b1, "after_rst");
        // back-to-back transforms, second one inverse
        clr_sched();
        s_start[0] = 1'b1;
        s_start[212] = 1'b1; s_inv[212] = 1'b1;
        run64(430);
        analyze(0, 1'b0, "b2b_first");
        analyze(212, 1'b1, "b2b_second");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
